// File: rtl/pong_pkg.sv
// Shared types for the AI paddle controller: FSM states and the per-difficulty
// tracking parameters (sample delay, cycles per pixel step, deadband).
package pong_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RETURN = 2'd2
    } ai_state_e;

    typedef struct packed {
        logic [3:0] delay;
        logic [2:0] ticks_per_px;
        logic [4:0] deadband;
    } diff_cfg_t;

    // Index is the difficulty level: 0 = easy (laggy, slow, sloppy) .. 3 = perfect.
    localparam diff_cfg_t DIFF_TABLE [0:3] = '{
        '{delay: 4'd6, ticks_per_px: 3'd4, deadband: 5'd16},
        '{delay: 4'd4, ticks_per_px: 3'd3, deadband: 5'd8},
        '{delay: 4'd2, ticks_per_px: 3'd2, deadband: 5'd4},
        '{delay: 4'd0, ticks_per_px: 3'd1, deadband: 5'd0}
    };

endpackage

// File: rtl/ai_delay_line.sv
// Ball-sample history: shifts din in on shift_en and exposes the sample taken
// `sel` ticks ago (sel = 0 is the live input).
module ai_delay_line #(
    parameter int DELAY_MAX = 8,
    parameter int Y_W       = 10,
    parameter int RESET_VAL = 240,
    localparam int SEL_W    = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [Y_W-1:0]   din,
    input  logic [SEL_W-1:0] sel,
    output logic [Y_W-1:0]   dout
);

    logic [Y_W-1:0] line_q [1:DELAY_MAX-1];
    logic [Y_W-1:0] line_d [1:DELAY_MAX-1];

    always_comb begin
        line_d = line_q;
        if (shift_en) begin
            line_d[1] = din;
            for (int k = 2; k < DELAY_MAX; k++) begin
                line_d[k] = line_q[k-1];
            end
        end
    end

    // Taps read the pre-shift contents, so tap k on a tick is the sample from k ticks ago.
    always_comb begin
        dout = din;
        for (int k = 1; k < DELAY_MAX; k++) begin
            if (int'(sel) == k) begin
                dout = line_q[k];
            end
        end
    end

    // NOTE: every entry is reset so the paddle starts from a known mid-screen history;
    // the line is tiny, so flops rather than RAM are the right storage here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k < DELAY_MAX; k++) begin
                line_q[k] <= Y_W'(RESET_VAL);
            end
        end else begin
            // NOTE: non-blocking so every stage shifts from the old contents in parallel.
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/ai_paddle_ctrl.sv
// Computer-controlled paddle: follows a delayed ball sample while the ball approaches,
// drifts back to centre otherwise, at a speed/precision set by the difficulty level.
module ai_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_H  = 480,
    parameter int PADDLE_H  = 64,
    parameter int Y_W       = 10,
    parameter int DELAY_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           game_on,
    input  logic [1:0]     diff,
    input  logic           sample_tick,
    input  logic [Y_W-1:0] ball_y,
    input  logic           ball_toward,
    output logic [Y_W-1:0] position,
    output logic           moving_up,
    output logic           moving_down
);

    localparam int SEL_W = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
    localparam int HOME  = (SCREEN_H - PADDLE_H) / 2;
    localparam int PMAX  = SCREEN_H - PADDLE_H;

    localparam logic [Y_W-1:0] HOME_Y     = Y_W'(HOME);
    localparam logic [Y_W-1:0] PMAX_Y     = Y_W'(PMAX);
    localparam logic [Y_W-1:0] HALF_Y     = Y_W'(PADDLE_H / 2);
    localparam logic [Y_W-1:0] HOME_MID_Y = Y_W'(HOME + PADDLE_H / 2);
    localparam logic [Y_W-1:0] MID_Y      = Y_W'(SCREEN_H / 2);
    localparam logic [Y_W-1:0] ONE_Y      = Y_W'(1);

    ai_state_e      state_q, state_d;
    logic [Y_W-1:0] pos_q, pos_d;
    logic [Y_W-1:0] target_q, target_d;
    logic [1:0]     diff_q, diff_d;
    logic [2:0]     tick_q, tick_d;
    logic           dir_q, dir_d;
    logic           up_q, up_d;
    logic           dn_q, dn_d;

    logic [3:0]       delay_lvl;
    logic [SEL_W-1:0] tap_sel;
    logic [Y_W-1:0]   tap_y;
    logic [2:0]       rate;
    logic [4:0]       db_eff;
    logic [Y_W-1:0]   goal;
    logic [Y_W:0]     err;
    logic [Y_W:0]     err_mag;
    logic             go_down;
    logic             want;
    logic             blocked;
    logic             run;
    logic             step;
    logic [2:0]       tick_eff;

    // The tap depth follows the level being latched on this tick, not the old one.
    always_comb begin
        delay_lvl = DIFF_TABLE[diff].delay;
        if (int'(delay_lvl) > DELAY_MAX - 1) begin
            tap_sel = SEL_W'(DELAY_MAX - 1);
        end else begin
            tap_sel = SEL_W'(delay_lvl);
        end
    end

    ai_delay_line #(
        .DELAY_MAX (DELAY_MAX),
        .Y_W       (Y_W),
        .RESET_VAL (SCREEN_H / 2)
    ) u_delay_line (
        .clk      (clk),
        .reset    (reset),
        .shift_en (sample_tick),
        .din      (ball_y),
        .sel      (tap_sel),
        .dout     (tap_y)
    );

    // NOTE: every output of this block gets a default up front so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        diff_d   = diff_q;
        tick_d   = '0;
        dir_d    = dir_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;

        if (sample_tick) begin
            target_d = tap_y;
            diff_d   = diff;
        end

        if (!game_on) begin
            state_d = ST_OFF;
        end else if (ball_toward) begin
            state_d = ST_TRACK;
        end else begin
            state_d = ST_RETURN;
        end

        rate    = DIFF_TABLE[diff_q].ticks_per_px;
        db_eff  = (state_q == ST_RETURN) ? 5'd0 : DIFF_TABLE[diff_q].deadband;
        goal    = (state_q == ST_TRACK) ? target_q : HOME_MID_Y;
        err     = {1'b0, goal} - {1'b0, pos_q + HALF_Y};
        err_mag = err[Y_W] ? -err : err;
        go_down = !err[Y_W];

        // game_on gates motion directly so a pause freezes the paddle on the very next edge.
        want    = game_on && (state_q != ST_OFF) && (err_mag > (Y_W+1)'(db_eff));
        blocked = go_down ? (pos_q == PMAX_Y) : (pos_q == '0);
        run     = want && !blocked;

        tick_eff = (dir_q != go_down) ? 3'd0 : tick_q;
        step     = run && (tick_eff >= rate - 3'd1);

        if (run) begin
            dir_d  = go_down;
            tick_d = step ? 3'd0 : tick_eff + 3'd1;
        end

        if (step) begin
            pos_d = go_down ? pos_q + ONE_Y : pos_q - ONE_Y;
            up_d  = !go_down;
            dn_d  = go_down;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_OFF;
            pos_q    <= HOME_Y;
            target_q <= MID_Y;
            diff_q   <= 2'd0;
            tick_q   <= 3'd0;
            dir_q    <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            diff_q   <= diff_d;
            tick_q   <= tick_d;
            dir_q    <= dir_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
        end
    end

    assign position    = pos_q;
    assign moving_up   = up_q;
    assign moving_down = dn_q;

endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Self-checking bench for ai_paddle_ctrl: directed scenarios plus random play,
// all compared cycle by cycle against a behavioural model of the paddle.
module tb_ai_paddle_ctrl;

    localparam int SCREEN_H  = 480;
    localparam int PADDLE_H  = 64;
    localparam int Y_W       = 10;
    localparam int DELAY_MAX = 8;
    localparam int HOME      = (SCREEN_H - PADDLE_H) / 2;
    localparam int PMAX      = SCREEN_H - PADDLE_H;
    localparam int HALF      = PADDLE_H / 2;

    localparam int LVL_D  [4] = '{6, 4, 2, 0};
    localparam int LVL_T  [4] = '{4, 3, 2, 1};
    localparam int LVL_DB [4] = '{16, 8, 4, 0};

    logic           clk = 1'b0;
    logic           reset;
    logic           game_on;
    logic [1:0]     diff;
    logic           sample_tick;
    logic [Y_W-1:0] ball_y;
    logic           ball_toward;
    logic [Y_W-1:0] position;
    logic           moving_up;
    logic           moving_down;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = off, 1 = chasing the delayed ball, 2 = heading home.
    int m_pos;
    bit m_up;
    bit m_dn;
    int m_mode;
    int m_target;
    int m_level;
    int m_run;
    bit m_last_down;
    int m_hist[$];

    ai_paddle_ctrl #(
        .SCREEN_H  (SCREEN_H),
        .PADDLE_H  (PADDLE_H),
        .Y_W       (Y_W),
        .DELAY_MAX (DELAY_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .game_on     (game_on),
        .diff        (diff),
        .sample_tick (sample_tick),
        .ball_y      (ball_y),
        .ball_toward (ball_toward),
        .position    (position),
        .moving_up   (moving_up),
        .moving_down (moving_down)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos       = HOME;
        m_up        = 1'b0;
        m_dn        = 1'b0;
        m_mode      = 0;
        m_target    = SCREEN_H / 2;
        m_level     = 0;
        m_run       = 0;
        m_last_down = 1'b0;
        m_hist      = {};
        for (int i = 0; i < DELAY_MAX - 1; i++) m_hist.push_back(SCREEN_H / 2);
    endtask

    // One clock edge of the paddle, from the inputs the bench is currently driving.
    task automatic model_step();
        int goal;
        int err;
        int mag;
        bit down;
        bit at_limit;
        int next_mode;
        if (!reset) begin
            model_reset();
            return;
        end
        next_mode = !game_on ? 0 : (ball_toward ? 1 : 2);
        goal = (m_mode == 1) ? m_target : HOME + HALF;
        err  = goal - (m_pos + HALF);
        mag  = (err < 0) ? -err : err;
        down = (err > 0);
        at_limit = down ? (m_pos == PMAX) : (m_pos == 0);
        m_up = 1'b0;
        m_dn = 1'b0;
        if (game_on && m_mode != 0 && mag > ((m_mode == 2) ? 0 : LVL_DB[m_level]) && !at_limit) begin
            if (down != m_last_down) m_run = 0;
            m_last_down = down;
            m_run++;
            if (m_run >= LVL_T[m_level]) begin
                m_run = 0;
                m_pos = down ? m_pos + 1 : m_pos - 1;
                m_up  = !down;
                m_dn  = down;
            end
        end else begin
            m_run = 0;
        end
        if (sample_tick) begin
            m_target = (LVL_D[diff] == 0) ? int'(ball_y) : m_hist[LVL_D[diff] - 1];
            m_hist.push_front(int'(ball_y));
            void'(m_hist.pop_back());
            m_level = diff;
        end
        m_mode = next_mode;
    endtask

    // Advance one clock; outputs are then observed at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    task automatic tick_cycle(input logic [Y_W-1:0] y);
        ball_y      = y;
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; game_on = 1'b0; diff = 2'd3; sample_tick = 1'b1;
        ball_y = 10'd5; ball_toward = 1'b1;
        model_reset();
        repeat (3) cycle();
        if (position !== Y_W'(HOME) || moving_up !== 1'b0 || moving_down !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: pos=%0d up=%b dn=%b expected pos=%0d up=0 dn=0",
                     position, moving_up, moving_down, HOME);
        end
        checks++;
        sample_tick = 1'b0; diff = 2'd0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (position !== Y_W'(m_pos) || moving_up !== m_up || moving_down !== m_dn) begin
                errors++;
                $display("FAIL reset_idle: pos=%0d up=%b dn=%b expected pos=%0d up=%b dn=%b",
                         position, moving_up, moving_down, m_pos, m_up, m_dn);
            end
            checks++;
        end
    endtask

    task automatic test_track_l3();
        diff = 2'd3; game_on = 1'b1; ball_toward = 1'b1;
        repeat (2) cycle();
        tick_cycle(10'd400);
        for (int i = 0; i < 160; i++) begin
            cycle();
            if (position !== Y_W'(m_pos) || moving_up !== m_up || moving_down !== m_dn) begin
                errors++;
                $display("FAIL track_l3 model: pos=%0d up=%b dn=%b expected pos=%0d up=%b dn=%b",
                         position, moving_up, moving_down, m_pos, m_up, m_dn);
            end
            checks++;
            if (moving_down !== 1'b1) begin
                errors++;
                $display("FAIL track_l3 every_cycle: step %0d moving_down=%b expected 1", i, moving_down);
            end
            checks++;
        end
        cycle();
        if (position !== 10'd368 || moving_down !== 1'b0 || moving_up !== 1'b0) begin
            errors++;
            $display("FAIL track_l3 stop: pos=%0d up=%b dn=%b expected pos=368 up=0 dn=0",
                     position, moving_up, moving_down);
        end
        checks++;
    endtask

    task automatic test_lower_limit();
        tick_cycle(10'd479);
        for (int i = 0; i < 48; i++) begin
            cycle();
            if (position !== Y_W'(m_pos) || moving_up !== m_up || moving_down !== m_dn) begin
                errors++;
                $display("FAIL lower_limit model: pos=%0d up=%b dn=%b expected pos=%0d up=%b dn=%b",
                         position, moving_up, moving_down, m_pos, m_up, m_dn);
            end
            checks++;
        end
        if (position !== Y_W'(PMAX) || moving_down !== 1'b1) begin
            errors++;
            $display("FAIL lower_limit reach: pos=%0d dn=%b expected pos=%0d dn=1", position, moving_down, PMAX);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (position !== Y_W'(PMAX) || moving_down !== 1'b0 || moving_up !== 1'b0) begin
                errors++;
                $display("FAIL lower_limit hold: pos=%0d up=%b dn=%b expected pos=%0d up=0 dn=0",
                         position, moving_up, moving_down, PMAX);
            end
            checks++;
        end
    endtask

    task automatic test_return();
        tick_cycle(10'd332);
        for (int i = 0; i < 116; i++) begin
            cycle();
            if (position !== Y_W'(m_pos) || moving_up !== m_up || moving_down !== m_dn) begin
                errors++;
                $display("FAIL return approach: pos=%0d up=%b dn=%b expected pos=%0d up=%b dn=%b",
                         position, moving_up, moving_down, m_pos, m_up, m_dn);
            end
            checks++;
        end
        if (position !== 10'd300) begin
            errors++;
            $display("FAIL return start_pos: pos=%0d expected 300", position);
        end
        checks++;
        ball_toward = 1'b0;
        cycle();
        for (int i = 0; i < 92; i++) begin
            cycle();
            if (position !== Y_W'(m_pos) || moving_up !== m_up || moving_down !== m_dn) begin
                errors++;
                $display("FAIL return model: pos=%0d up=%b dn=%b expected pos=%0d up=%b dn=%b",
                         position, moving_up, moving_down, m_pos, m_up, m_dn);
            end
            checks++;
            if (moving_up !== 1'b1) begin
                errors++;
                $display("FAIL return moving_up: step %0d moving_up=%b expected 1", i, moving_up);
            end
            checks++;
        end
        repeat (3) cycle();
        if (position !== Y_W'(HOME) || moving_up !== 1'b0 || moving_down !== 1'b0) begin
            errors++;
            $display("FAIL return idle: pos=%0d up=%b dn=%b expected pos=%0d up=0 dn=0",
                     position, moving_up, moving_down, HOME);
        end
        checks++;
    endtask

    task automatic test_level0();
        bit exp_dn;
        pulse_reset();
        diff = 2'd0; game_on = 1'b1; ball_toward = 1'b1;
        cycle();
        // Seven ticks of 250 push it through tap 6; ten pixels of error sits inside the deadband.
        for (int t = 0; t < 14; t++) begin
            if (t < 7) tick_cycle(10'd250);
            else tick_cycle(10'd400);
            repeat (2) cycle();
            if (position !== Y_W'(HOME) || moving_up !== 1'b0 || moving_down !== 1'b0 ||
                position !== Y_W'(m_pos)) begin
                errors++;
                $display("FAIL level0 deadband: tick %0d pos=%0d up=%b dn=%b expected pos=%0d idle",
                         t, position, moving_up, moving_down, HOME);
            end
            checks++;
        end
        // The seventh 400 tick happened two cycles ago: motion began on those two cycles.
        for (int i = 2; i < 40; i++) begin
            cycle();
            exp_dn = ((i % 4) == 3);
            if (moving_down !== exp_dn || position !== Y_W'(m_pos) || moving_down !== m_dn) begin
                errors++;
                $display("FAIL level0 rate: cycle %0d pos=%0d dn=%b expected pos=%0d dn=%b",
                         i, position, moving_down, m_pos, exp_dn);
            end
            checks++;
        end
        if (position !== Y_W'(HOME + 10)) begin
            errors++;
            $display("FAIL level0 distance: pos=%0d expected %0d", position, HOME + 10);
        end
        checks++;
    endtask

    task automatic test_pause();
        bit exp_dn;
        logic [Y_W-1:0] frozen;
        repeat (2) cycle();
        frozen  = position;
        game_on = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (position !== frozen || moving_up !== 1'b0 || moving_down !== 1'b0) begin
                errors++;
                $display("FAIL pause freeze: cycle %0d pos=%0d up=%b dn=%b expected pos=%0d up=0 dn=0",
                         i, position, moving_up, moving_down, frozen);
            end
            checks++;
        end
        game_on = 1'b1;
        cycle();
        for (int i = 0; i < 12; i++) begin
            cycle();
            exp_dn = ((i % 4) == 3);
            if (moving_down !== exp_dn || position !== Y_W'(m_pos) || moving_down !== m_dn) begin
                errors++;
                $display("FAIL pause resume: cycle %0d pos=%0d dn=%b expected pos=%0d dn=%b",
                         i, position, moving_down, m_pos, exp_dn);
            end
            checks++;
        end
    endtask

    task automatic test_async_reset();
        diff = 2'd3;
        tick_cycle(10'd440);
        repeat (5) cycle();
        if (moving_down !== 1'b1 || position === Y_W'(HOME) || position !== Y_W'(m_pos)) begin
            errors++;
            $display("FAIL async_reset premove: pos=%0d dn=%b expected pos=%0d dn=1", position, moving_down, m_pos);
        end
        checks++;
        #2 reset = 1'b0;
        #1;
        if (position !== Y_W'(HOME) || moving_up !== 1'b0 || moving_down !== 1'b0) begin
            errors++;
            $display("FAIL async_reset immediate: pos=%0d up=%b dn=%b expected pos=%0d up=0 dn=0",
                     position, moving_up, moving_down, HOME);
        end
        checks++;
        model_reset();
        repeat (2) cycle();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (position !== Y_W'(m_pos) || moving_up !== m_up || moving_down !== m_dn) begin
                errors++;
                $display("FAIL async_reset after: pos=%0d up=%b dn=%b expected pos=%0d up=%b dn=%b",
                         position, moving_up, moving_down, m_pos, m_up, m_dn);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        pulse_reset();
        game_on = 1'b1; ball_toward = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            game_on     = ($urandom_range(0, 59) != 0);
            sample_tick = ($urandom_range(0, 5) == 0);
            ball_y      = Y_W'($urandom_range(0, SCREEN_H - 1));
            if ($urandom_range(0, 39) == 0) ball_toward = ~ball_toward;
            if ($urandom_range(0, 99) == 0) diff = 2'($urandom_range(0, 3));
            cycle();
            if (position !== Y_W'(m_pos) || moving_up !== m_up || moving_down !== m_dn) begin
                errors++;
                $display("FAIL random cycle %0d: pos=%0d up=%b dn=%b expected pos=%0d up=%b dn=%b",
                         i, position, moving_up, moving_down, m_pos, m_up, m_dn);
            end
            checks++;
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_track_l3();
        test_lower_limit();
        test_return();
        test_level0();
        test_pause();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ai_paddle_ctrl.md
AI_PADDLE_CTRL -- requirements
Module: ai_paddle_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_H, default 480, the playfield height in px.
REQ-002 SHALL have parameter PADDLE_H, default 64, the paddle height in px.
REQ-003 SHALL have parameter Y_W, default 10, the coordinate width in bits.
REQ-004 SHALL have parameter DELAY_MAX, default 8, the ball-sample delay-line depth.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port game_on, input, 1 bit: play enabled.
REQ-008 SHALL have port diff, input, 2 bits: difficulty level 0 (easy) to 3 (perfect).
REQ-009 SHALL have port sample_tick, input, 1 bit: one-cycle strobe that samples ball_y.
REQ-010 SHALL have port ball_y, input, Y_W bits: ball vertical centre; y increases downward.
REQ-011 SHALL have port ball_toward, input, 1 bit: the ball is travelling toward this paddle.
REQ-012 SHALL have port position, output, Y_W bits: paddle top edge in px.
REQ-013 SHALL have port moving_up, output, 1 bit: position decremented this cycle.
REQ-014 SHALL have port moving_down, output, 1 bit: position incremented this cycle.

Function
REQ-015 SHALL use constants HOME = (SCREEN_H-PADDLE_H)/2 (208 at defaults) and PMAX = SCREEN_H-PADDLE_H (416 at defaults).
REQ-016 SHALL select the per-level table {delay D, ticks-per-px T, deadband DB} as: level 0 {6,4,16}, level 1 {4,3,8}, level 2 {2,2,4}, level 3 {0,1,0}.
REQ-017 SHALL shift ball_y into the delay line on each sample_tick and load the target register from tap D in the same cycle; tap 0 is the current ball_y.
REQ-018 SHALL latch diff only on sample_tick; a change to diff between ticks has no effect until the next tick.
REQ-019 SHALL implement FSM states OFF, TRACK and RETURN.
- OFF: entered when game_on=0; position held; both moving flags 0.
- OFF -> TRACK when game_on=1 and ball_toward=1.
- OFF -> RETURN when game_on=1 and ball_toward=0.
- TRACK <-> RETURN follow ball_toward, evaluated every cycle.
- Any state -> OFF when game_on=0; this has priority over all other transitions.
REQ-020 SHALL use the delayed ball sample as the goal in TRACK and the centre of a paddle at HOME (HOME+PADDLE_H/2) as the goal in RETURN.
REQ-021 SHALL compute err = goal - (position + PADDLE_H/2) as a signed Y_W+1-bit value, and SHALL not move when |err| <= DB.
- In RETURN, DB is treated as 0.
REQ-022 SHALL step position by exactly 1 px once every T cycles while motion is requested, toward the sign of err, using a tick counter.
REQ-023 SHALL clear the tick counter on any direction change, on entry to OFF, and whenever motion stops.
REQ-024 SHALL saturate position to 0..PMAX, and SHALL not assert a moving flag when a step is blocked by a limit.
REQ-025 SHALL register moving_up and moving_down, which are mutually exclusive and high only in a cycle where position changes.
REQ-026 SHALL have 1-cycle latency from a goal change to the first evaluation of err.

Reset
REQ-027 SHALL, while reset=0, set position=HOME, moving_up=0, moving_down=0, state OFF, tick counter 0, every delay-line entry = SCREEN_H/2, target = SCREEN_H/2 and latched diff = 0.
REQ-028 SHALL, when reset is asserted mid-move, force the outputs to their reset values immediately, with no clock edge required.

Structure
REQ-029 SHALL define the state enum, the difficulty-table record type and the 4-entry difficulty-table constant in the shared package pong_pkg.
REQ-030 SHALL place the delay line in sub-module ai_delay_line, parameterised by DELAY_MAX and Y_W.

Verification
REQ-031 Bench SHALL cover level-3 tracking: diff=3, game_on=1, ball_toward=1, ball_y=400, tick -> moving_down on every cycle, stopping at position=368.
REQ-032 Bench SHALL cover the lower limit: diff=3, ball_y=479 -> position stops at 416 and moving_down drops the cycle after the limit.
REQ-033 Bench SHALL cover level-0 rate and deadband: diff=0, ball_y=250 -> no motion (err=10 <= 16); ball_y=400 reaching tap 6 after 6 ticks -> one step per 4 cycles.
REQ-034 Bench SHALL cover return: from position=300, set ball_toward=0 -> moving_up until position=208, then idle.
REQ-035 Bench SHALL cover pause: game_on=0 mid-move -> flags 0 the next cycle and position frozen; re-enable -> motion resumes with a fresh tick count.
REQ-036 Bench SHALL cover asynchronous reset: reset low mid-move, between clock edges -> position=208 and flags 0 without a clock edge.
